// File: rtl/spram_pkg.sv
// Shared types and helpers for the single-port byte-write RAM.
package spram_pkg;

   localparam int MAX_READ_LATENCY = 8;

   typedef enum logic [1:0] {
      WM_READ_FIRST,
      WM_WRITE_FIRST,
      WM_NO_CHANGE
   } wmode_e;

   // Unknown strings fall back to read_first; wmode_legal() reports them.
   function automatic wmode_e wmode_from_str(input string s);
      if (s == "write_first") return WM_WRITE_FIRST;
      if (s == "no_change")   return WM_NO_CHANGE;
      return WM_READ_FIRST;
   endfunction

   function automatic bit wmode_legal(input string s);
      return (s == "read_first") || (s == "write_first") || (s == "no_change");
   endfunction

endpackage

// File: rtl/spram_out_pipe.sv
// N-stage read-data delay: stage 1 loads on ld, middle stages shift every
// clock, last stage (douta) is regce-gated and reset-loaded.
module spram_out_pipe
   import spram_pkg::*;
#(
   parameter int             W       = 64,
   parameter int             N       = 1,
   parameter logic [W-1:0]   RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ld,
   input  logic         regce,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   if (N == 1) begin : g_single
      // Stage 1 is the output; regce has no role here.
      logic unused_regce;
      assign unused_regce = regce;

      always_ff @(posedge clk) begin
         if (!rst_n)  q <= RST_VAL;
         else if (ld) q <= d;
      end
   end else begin : g_multi
      logic [W-1:0] stg [1:N-1];

      always_ff @(posedge clk) begin
         if (ld) stg[1] <= d;
         for (int i = 2; i < N; i++) stg[i] <= stg[i-1];
      end

      always_ff @(posedge clk) begin
         if (!rst_n)     q <= RST_VAL;
         else if (regce) q <= stg[N-1];
      end
   end

endmodule

// File: rtl/spram_bytewrite.sv
// Single-port byte-write RAM with configurable read latency and write mode.
// Optional SPRAM_SIM_ASSERT_EN adds parameter and X/Z checks for simulation.
module spram_bytewrite
   import spram_pkg::*;
#(
   parameter int                      ADDR_WIDTH_A       = 13,
   parameter int                      DATA_WIDTH_A       = 64,
   parameter int                      BYTE_WRITE_WIDTH_A = 8,
   parameter int                      READ_LATENCY_A     = 1,
   parameter string                   WRITE_MODE_A       = "read_first",
   parameter logic [DATA_WIDTH_A-1:0] READ_RESET_VALUE_A = '0,
   localparam int                     NB = DATA_WIDTH_A / BYTE_WRITE_WIDTH_A
) (
   input  logic                    clka,
   input  logic                    rsta_n,
   input  logic                    ena,
   input  logic                    regcea,
   input  logic                    sleep,
   input  logic [ADDR_WIDTH_A-1:0] addra,
   input  logic [NB-1:0]           wea,
   input  logic [DATA_WIDTH_A-1:0] dina,
   output logic [DATA_WIDTH_A-1:0] douta,
   input  logic                    injectsbiterra,
   input  logic                    injectdbiterra
);

   localparam int     BW    = BYTE_WRITE_WIDTH_A;
   localparam int     DEPTH = 2 ** ADDR_WIDTH_A;
   localparam wmode_e WMODE = wmode_from_str(WRITE_MODE_A);

   // No ECC behind this macro; injection pins exist only for drop-in compatibility.
   logic unused_inject;
   assign unused_inject = injectsbiterra ^ injectdbiterra;

   // Array carries no reset; inferred block RAM powers up zeroed.
   logic [DATA_WIDTH_A-1:0] mem [DEPTH];
   logic [DATA_WIDTH_A-1:0] old_word, new_word, s1_d;
   logic                    acc, ld;

   assign acc      = ena & ~sleep;
   assign old_word = mem[addra];

   always_comb begin
      new_word = old_word;
      for (int i = 0; i < NB; i++)
         if (wea[i]) new_word[i*BW +: BW] = dina[i*BW +: BW];
   end

   always_ff @(posedge clka) begin
      for (int i = 0; i < NB; i++)
         if (acc && wea[i]) mem[addra][i*BW +: BW] <= dina[i*BW +: BW];
   end

   always_comb begin
      ld   = acc;
      s1_d = old_word;
      case (WMODE)
         WM_WRITE_FIRST: s1_d = new_word;
         WM_NO_CHANGE:   ld   = acc && (wea == '0);
         default: ;
      endcase
   end

   spram_out_pipe #(
      .W       (DATA_WIDTH_A),
      .N       (READ_LATENCY_A),
      .RST_VAL (READ_RESET_VALUE_A)
   ) u_pipe (
      .clk   (clka),
      .rst_n (rsta_n),
      .ld    (ld),
      .regce (regcea),
      .d     (s1_d),
      .q     (douta)
   );

`ifdef SPRAM_SIM_ASSERT_EN
   if (DATA_WIDTH_A % BYTE_WRITE_WIDTH_A != 0) begin : g_bad_bw
      $error("spram_bytewrite: BYTE_WRITE_WIDTH_A must divide DATA_WIDTH_A");
   end
   if (READ_LATENCY_A < 1 || READ_LATENCY_A > MAX_READ_LATENCY) begin : g_bad_lat
      $error("spram_bytewrite: READ_LATENCY_A out of range 1..8");
   end
   if (!wmode_legal(WRITE_MODE_A)) begin : g_bad_wm
      $error("spram_bytewrite: illegal WRITE_MODE_A");
   end

   always @(posedge clka) begin
      assert (!$isunknown(rsta_n)) else $error("spram_bytewrite: rsta_n is X/Z");
      if (ena === 1'b1)
         assert (!$isunknown({addra, wea})) else $error("spram_bytewrite: addra/wea X/Z while enabled");
   end
`endif

endmodule

// File: tb/tb_spram_bytewrite.sv
// Directed bench: four instances (read_first, write_first, no_change at latency 1,
// read_first at latency 3) share one stimulus stream; each output is checked.
module tb_spram_bytewrite;

   localparam int AW = 13;
   localparam int DW = 64;
   localparam int NB = 8;
   localparam logic [DW-1:0] RV3 = 64'hDEAD;

   logic          clka = 1'b0;
   logic          rsta_n, ena, regcea, sleep;
   logic [AW-1:0] addra;
   logic [NB-1:0] wea;
   logic [DW-1:0] dina;
   logic [DW-1:0] q_rf, q_wf, q_nc, q_l3;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clka = ~clka;

   spram_bytewrite #(.WRITE_MODE_A("read_first")) u_rf (
      .clka(clka), .rsta_n(rsta_n), .ena(ena), .regcea(regcea), .sleep(sleep),
      .addra(addra), .wea(wea), .dina(dina), .douta(q_rf),
      .injectsbiterra(1'b0), .injectdbiterra(1'b0));

   spram_bytewrite #(.WRITE_MODE_A("write_first")) u_wf (
      .clka(clka), .rsta_n(rsta_n), .ena(ena), .regcea(regcea), .sleep(sleep),
      .addra(addra), .wea(wea), .dina(dina), .douta(q_wf),
      .injectsbiterra(1'b0), .injectdbiterra(1'b0));

   spram_bytewrite #(.WRITE_MODE_A("no_change")) u_nc (
      .clka(clka), .rsta_n(rsta_n), .ena(ena), .regcea(regcea), .sleep(sleep),
      .addra(addra), .wea(wea), .dina(dina), .douta(q_nc),
      .injectsbiterra(1'b0), .injectdbiterra(1'b0));

   spram_bytewrite #(.READ_LATENCY_A(3), .READ_RESET_VALUE_A(RV3)) u_l3 (
      .clka(clka), .rsta_n(rsta_n), .ena(ena), .regcea(regcea), .sleep(sleep),
      .addra(addra), .wea(wea), .dina(dina), .douta(q_l3),
      .injectsbiterra(1'b1), .injectdbiterra(1'b1));

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Inputs change 1ns after a rising edge; outputs are sampled there too.
   task automatic step();
      @(posedge clka);
      #1;
   endtask

   task automatic drive(input logic e, input logic [AW-1:0] a, input logic [NB-1:0] w,
                        input logic [DW-1:0] d);
      ena = e; addra = a; wea = w; dina = d;
   endtask

   initial begin
      rsta_n = 1'b0; ena = 1'b0; regcea = 1'b1; sleep = 1'b0;
      addra = '0; wea = '0; dina = '0;
      step(); step();
      check("rst_rf", q_rf, 64'h0);
      check("rst_wf", q_wf, 64'h0);
      check("rst_nc", q_nc, 64'h0);
      check("rst_l3", q_l3, RV3);
      rsta_n = 1'b1;

      // full write, then read back
      drive(1, 5, 8'hFF, 64'h1122334455667788); step();
      check("wf_full_wr", q_wf, 64'h1122334455667788);
      check("nc_full_wr_hold", q_nc, 64'h0);
      drive(1, 5, 8'h00, 64'h0); step();
      check("rf_rd5", q_rf, 64'h1122334455667788);
      check("nc_rd5", q_nc, 64'h1122334455667788);

      // partial lane write
      drive(1, 5, 8'h0F, 64'hAAAAAAAABBBBBBBB); step();
      check("rf_part_old", q_rf, 64'h1122334455667788);
      check("wf_part_merged", q_wf, 64'h11223344BBBBBBBB);
      check("nc_part_hold", q_nc, 64'h1122334455667788);
      drive(1, 5, 8'h00, 64'h0); step();
      check("rf_part_rd", q_rf, 64'h11223344BBBBBBBB);
      check("nc_part_rd", q_nc, 64'h11223344BBBBBBBB);

      // same-cycle collision semantics
      drive(1, 7, 8'hFF, 64'h42); step();
      drive(1, 5, 8'hFF, 64'h0123); step();
      drive(1, 7, 8'h00, 64'h0); step();
      check("nc_rd7", q_nc, 64'h42);
      drive(1, 5, 8'hFF, '1); step();
      check("rf_coll", q_rf, 64'h0123);
      check("wf_coll", q_wf, '1);
      check("nc_coll", q_nc, 64'h42);
      drive(1, 5, 8'h00, 64'h0); step();
      check("rf_coll_rd", q_rf, '1);

      // latency-3 pipeline and regcea hold
      drive(0, 5, 8'h00, 64'h0); step(); step(); step();
      check("l3_flush", q_l3, '1);
      drive(1, 7, 8'h00, 64'h0); step();
      drive(0, 0, 8'h00, 64'h0); step();
      check("l3_e1", q_l3, '1);
      regcea = 1'b0; step();
      check("l3_regce_hold", q_l3, '1);
      regcea = 1'b1; step();
      check("l3_e_out", q_l3, 64'h42);
      drive(1, 5, 8'h00, 64'h0); step();
      drive(0, 0, 8'h00, 64'h0); step();
      regcea = 1'b0; step(); step();
      check("l3_hold_42", q_l3, 64'h42);
      regcea = 1'b1; step();
      check("l3_release", q_l3, '1);

      // reset mid-stream; write in reset cycle commits
      rsta_n = 1'b0; drive(1, 9, 8'hFF, 64'h99); step();
      check("rst_mid_rf", q_rf, 64'h0);
      check("rst_mid_l3", q_l3, RV3);
      rsta_n = 1'b1; drive(1, 7, 8'h00, 64'h0); step();
      check("post_rst_rd7", q_rf, 64'h42);
      drive(1, 9, 8'h00, 64'h0); step();
      check("rst_wr_commit", q_rf, 64'h99);

      // ena=0 / sleep=1 block access
      drive(0, 9, 8'hFF, 64'h5555); step();
      check("ena0_rf_hold", q_rf, 64'h99);
      check("ena0_wf_hold", q_wf, 64'h99);
      sleep = 1'b1; drive(1, 9, 8'hFF, 64'h6666); step();
      check("sleep_rf_hold", q_rf, 64'h99);
      check("sleep_wf_hold", q_wf, 64'h99);
      sleep = 1'b0; drive(1, 9, 8'h00, 64'h0); step();
      check("sleep_mem_rf", q_rf, 64'h99);
      check("sleep_mem_nc", q_nc, 64'h99);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/spram_bytewrite.md
# spram_bytewrite

Single-port, byte-write-enabled synchronous RAM with a configurable read pipeline, behaviourally compatible with the vendor single-port macro it replaces. It is the storage primitive under cache data/tag arrays and scratch memories. One clock, one address port shared by read and write, per-byte write strobes, and read-first collision semantics by default.

## Interface
- ADDR_WIDTH_A, 13: address bits; depth = 2**ADDR_WIDTH_A words.
- DATA_WIDTH_A, 64: word width; read and write widths are equal.
- BYTE_WRITE_WIDTH_A, 8: bits per write lane; must divide DATA_WIDTH_A; NB = DATA_WIDTH_A/BYTE_WRITE_WIDTH_A.
- READ_LATENCY_A, 1: cycles from accepted address to douta; legal 1..8.
- WRITE_MODE_A, "read_first": "read_first" | "write_first" | "no_change".
- READ_RESET_VALUE_A, 0: value loaded into douta on reset.
- clka  in  1  clock; all state updates on rising edge.
- rsta_n  in  1  synchronous, active-low reset of the output stage.
- ena  in  1  port enable; gates both read capture and write.
- regcea  in  1  clock enable of final output stage (used when READ_LATENCY_A >= 2).
- sleep  in  1  when high, no access occurs (treated as ena=0).
- addra  in  ADDR_WIDTH_A  word address.
- wea  in  NB  per-lane write strobes; wea[i] covers dina[i*B +: B].
- dina  in  DATA_WIDTH_A  write data.
- douta  out  DATA_WIDTH_A  read data.
- injectsbiterra, injectdbiterra  in  1  accepted and ignored (no ECC).

## Operation
- Memory array is initialised to all zero at time zero; never cleared by reset.
- Access when ena=1 and sleep=0 at a rising edge; otherwise array and stage-1 register hold.
- Write: each lane i with wea[i]=1 takes dina lane i at addra; other lanes unchanged. wea=0 is a pure read.
- Stage-1 read data on an access cycle:
  - read_first: old contents of addra (pre-write).
  - write_first: merged new word (written lanes new, others old).
  - no_change: stage 1 updates only if wea==0; holds on any write.
- Pipeline: stage 1 captures as above; stages 2..N-1 advance every clock unconditionally; stage N (douta) advances only when regcea=1. For N=1, douta is stage 1 and regcea is ignored.
- Reset: rsta_n=0 at a rising edge loads douta with READ_RESET_VALUE_A; reset takes priority over regcea/ena for douta. Intermediate stages and array are unaffected; a write in the reset cycle still commits.
- Out-of-range addresses cannot occur (depth is a power of two).

## Timing
- Address/data sampled at edge k; douta valid after edge k+READ_LATENCY_A-1 (i.e. during cycle k+N), given regcea=1 at final edge.
- Write visible to a read issued at edge k+1 or later; same-edge behaviour per WRITE_MODE_A.
- Back-to-back accesses every cycle; throughput one access per clock.
- Power-up douta value is READ_RESET_VALUE_A.

## Configuration
- SPRAM_SIM_ASSERT_EN defined: elaboration checks (DATA_WIDTH_A % BYTE_WRITE_WIDTH_A == 0, READ_LATENCY_A in 1..8, legal WRITE_MODE_A) and runtime assertions flagging X/Z on addra or wea while ena=1, and on rsta_n at any edge.
- Undefined: no checks compiled; functional behaviour identical.

## Structure
- Package spram_pkg: write-mode enum (WM_READ_FIRST, WM_WRITE_FIRST, WM_NO_CHANGE), string-to-enum function, max-latency constant (8).
- Sub-module spram_out_pipe: parameterised N-stage delay with regce-gated, reset-loaded last stage.
- Top holds the array, lane-wise write loop, and mode-dependent stage-1 mux.

## Test plan
- Defaults, write addr 5 dina=0x1122334455667788 wea=0xFF, then read addr 5 -> douta=0x1122334455667788 one cycle after read edge.
- Partial write wea=0x0F dina=0xAAAAAAAABBBBBBBB to addr 5 -> subsequent read 0x11223344BBBBBBBB.
- Same-cycle write 0xFF..FF to addr 5 holding 0x0123: read_first -> douta=0x0123; write_first -> 0xFF..FF; no_change -> douta keeps prior value.
- READ_LATENCY_A=3: read addr 7 (value 0x42) at edge 0 -> douta=0x42 after edge 2; with regcea=0 at edge 2, douta holds until regcea=1.
- rsta_n=0 one cycle mid-stream with READ_RESET_VALUE_A=0 -> douta=0 next cycle; array contents intact on later reads.
- ena=0 or sleep=1 with wea=0xFF -> memory unchanged, stage-1/douta hold.
